// File: rtl/wt_pkg.sv
// Shared types and constants for the wavetable voice scheduler.
//
// Contents:
//   SAMPLE_IDX_W / PROG_W / FRAC_W / SAMPLE_W : ROM and datapath field widths
//   MAX_VID_W                                 : widest voice number (64 voices)
//   wt_state_e                                : frame FSM states
//   wt_stage_t                                : per-voice bundle carried down the pipeline
package wt_pkg;

  localparam int SAMPLE_IDX_W = 6;
  localparam int PROG_W       = 7;
  localparam int FRAC_W       = 8;
  localparam int SAMPLE_W     = 8;
  localparam int MAX_VID_W    = 6;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } wt_state_e;

  // The voice field is sized for the largest legal voice count so the
  // struct can be shared by every parameterisation.
  typedef struct packed {
    logic [MAX_VID_W-1:0] voice;
    logic [FRAC_W-1:0]    frac;
    logic                 gate;
  } wt_stage_t;

endpackage

// File: rtl/wt_interp.sv
// Two-stage linear interpolator between the sample ROM and the mixer.
//
// The issue-side fields (valid/voice/frac/gate) arrive in the ROM address
// cycle; s0/s1 arrive one cycle later with the ROM read data. Stage S1
// realigns the fields with the data, stage S2 registers the result.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   valid_i           a voice is being issued this cycle
//   voice_i           voice number being issued
//   frac_i            interpolation fraction of that voice
//   gate_i            voice enable; disabled voices emit 0x00
//   s0_i, s1_i        ROM samples at idx and idx+1 (one cycle after issue)
//   out_valid_o       out_voice_o/out_sample_o valid
//   out_voice_o       voice index of out_sample_o
//   out_sample_o      interpolated signed sample
module wt_interp
  import wt_pkg::*;
#(
  parameter int VID_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_i,
  input  logic [VID_W-1:0]    voice_i,
  input  logic [FRAC_W-1:0]   frac_i,
  input  logic                gate_i,
  input  logic [SAMPLE_W-1:0] s0_i,
  input  logic [SAMPLE_W-1:0] s1_i,
  output logic                out_valid_o,
  output logic [VID_W-1:0]    out_voice_o,
  output logic [SAMPLE_W-1:0] out_sample_o
);

  logic                s1_valid_q;
  wt_stage_t           s1_q, s1_d;
  logic                out_valid_q;
  logic [VID_W-1:0]    out_voice_q, out_voice_d;
  logic [SAMPLE_W-1:0] out_sample_q, out_sample_d;

  logic signed [8:0]  diff;
  logic signed [17:0] prod;
  logic        [9:0]  sum;

  always_comb begin
    s1_d       = '0;
    s1_d.voice = MAX_VID_W'(voice_i);
    s1_d.frac  = frac_i;
    s1_d.gate  = gate_i;
  end

  // |diff| <= 255 and frac <= 255, so prod[17:8] is exactly p >>> 8 and
  // s0 + (p >>> 8) always lands between s0 and s1: the low byte is the result.
  always_comb begin
    diff         = {s1_i[SAMPLE_W-1], s1_i} - {s0_i[SAMPLE_W-1], s0_i};
    prod         = diff * $signed({1'b0, s1_q.frac});
    sum          = {{2{s0_i[SAMPLE_W-1]}}, s0_i} + prod[17:8];
    out_voice_d  = s1_q.voice[VID_W-1:0];
    out_sample_d = s1_q.gate ? sum[SAMPLE_W-1:0] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_q         <= '0;
      out_valid_q  <= 1'b0;
      out_voice_q  <= '0;
      out_sample_q <= '0;
    end else begin
      s1_valid_q   <= valid_i;
      s1_q         <= s1_d;
      out_valid_q  <= s1_valid_q;
      out_voice_q  <= out_voice_d;
      out_sample_q <= out_sample_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_voice_o  = out_voice_q;
  assign out_sample_o = out_sample_q;

endmodule

// File: rtl/wavetable_voice_scheduler.sv
// Time-multiplexes VOICES wavetable voices onto a dual-port sample ROM,
// one voice per clock, and streams one interpolated sample per voice per
// audio frame to the mixer.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   sample_tick                  audio-rate pulse, starts a frame
//   cfg_we/voice/prog/step/gate  voice configuration write
//   ovr_clr                      clears the sticky overrun flag
//   rom_re_a/b                   ROM read enables (high for gated voices)
//   rom_addr_{a,b}_sample/prog   ROM addresses; B reads idx+1 (mod 64)
//   rom_data_a/b                 ROM data, one cycle after the read
//   out_valid/voice/sample       interpolated sample stream
//   frame_done                   pulse the cycle after the last output
//   busy                         frame in progress
//   overrun                      sticky: tick arrived while busy
module wavetable_voice_scheduler
  import wt_pkg::*;
#(
  parameter int VOICES  = 16,
  parameter int PHASE_W = 16,
  parameter int VID_W   = $clog2(VOICES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_tick,
  input  logic                    cfg_we,
  input  logic [VID_W-1:0]        cfg_voice,
  input  logic [PROG_W-1:0]       cfg_prog,
  input  logic [PHASE_W-1:0]      cfg_step,
  input  logic                    cfg_gate,
  input  logic                    ovr_clr,
  output logic                    rom_re_a,
  output logic                    rom_re_b,
  output logic [SAMPLE_IDX_W-1:0] rom_addr_a_sample,
  output logic [SAMPLE_IDX_W-1:0] rom_addr_b_sample,
  output logic [PROG_W-1:0]       rom_addr_a_prog,
  output logic [PROG_W-1:0]       rom_addr_b_prog,
  input  logic [SAMPLE_W-1:0]     rom_data_a,
  input  logic [SAMPLE_W-1:0]     rom_data_b,
  output logic                    out_valid,
  output logic [VID_W-1:0]        out_voice,
  output logic [SAMPLE_W-1:0]     out_sample,
  output logic                    frame_done,
  output logic                    busy,
  output logic                    overrun
);

  wt_state_e        state_q, state_d;
  logic [VID_W-1:0] v_q, v_d;
  logic             drain_q, drain_d;
  logic             overrun_q, overrun_d;
  logic             frame_done_q, frame_done_d;

  logic [PROG_W-1:0]  prog_q  [VOICES];
  logic [PROG_W-1:0]  prog_d  [VOICES];
  logic [PHASE_W-1:0] step_q  [VOICES];
  logic [PHASE_W-1:0] step_d  [VOICES];
  logic [PHASE_W-1:0] phase_q [VOICES];
  logic [PHASE_W-1:0] phase_d [VOICES];
  logic [VOICES-1:0]  gate_q, gate_d;

  logic                    issuing;
  logic [SAMPLE_IDX_W-1:0] idx;
  logic [FRAC_W-1:0]       frac;

  // Frame FSM and overrun flag.
  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    v_d          = v_q;
    drain_d      = drain_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;

    // Set after clear so a coinciding overrunning tick wins.
    if (ovr_clr) overrun_d = 1'b0;
    if (sample_tick && state_q != IDLE) overrun_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (sample_tick) begin
          state_d = ISSUE;
          v_d     = '0;
        end
      end
      ISSUE: begin
        if (v_q == VID_W'(VOICES - 1)) begin
          state_d = DRAIN;
          drain_d = 1'b0;
        end else begin
          v_d = v_q + 1'b1;
        end
      end
      DRAIN: begin
        // Two drain cycles cover the S1/S2 pipeline; frame_done lands on
        // the cycle right after the last out_valid.
        if (drain_q) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // S0: ROM addressing for the voice in its issue slot.
  always_comb begin
    issuing           = (state_q == ISSUE);
    idx               = phase_q[v_q][PHASE_W-1 -: SAMPLE_IDX_W];
    frac              = phase_q[v_q][PHASE_W-SAMPLE_IDX_W-1 -: FRAC_W];
    rom_re_a          = issuing & gate_q[v_q];
    rom_re_b          = issuing & gate_q[v_q];
    rom_addr_a_sample = issuing ? idx : '0;
    rom_addr_b_sample = issuing ? idx + 1'b1 : '0;  // 63 pairs with 0
    rom_addr_a_prog   = issuing ? prog_q[v_q] : '0;
    rom_addr_b_prog   = issuing ? prog_q[v_q] : '0;
  end

  // Voice state. Issue reads the registered values, so a config write to
  // the voice being issued only takes effect from the next frame.
  always_comb begin
    prog_d  = prog_q;
    step_d  = step_q;
    gate_d  = gate_q;
    phase_d = phase_q;
    if (issuing && gate_q[v_q]) phase_d[v_q] = phase_q[v_q] + step_q[v_q];
    if (cfg_we) begin
      prog_d[cfg_voice] = cfg_prog;
      step_d[cfg_voice] = cfg_step;
      gate_d[cfg_voice] = cfg_gate;
      // Enabling a silent voice restarts it; this overrides the accumulate.
      if (cfg_gate && !gate_q[cfg_voice]) phase_d[cfg_voice] = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      v_q          <= '0;
      drain_q      <= 1'b0;
      overrun_q    <= 1'b0;
      frame_done_q <= 1'b0;
      gate_q       <= '0;
      // NOTE: the voice arrays are small flop arrays, not RAM, and voices
      // must come up silent at phase 0, so they are reset explicitly.
      for (int i = 0; i < VOICES; i++) begin
        prog_q[i]  <= '0;
        step_q[i]  <= '0;
        phase_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      v_q          <= v_d;
      drain_q      <= drain_d;
      overrun_q    <= overrun_d;
      frame_done_q <= frame_done_d;
      gate_q       <= gate_d;
      prog_q       <= prog_d;
      step_q       <= step_d;
      phase_q      <= phase_d;
    end
  end

  wt_interp #(
    .VID_W (VID_W)
  ) u_interp (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (issuing),
    .voice_i      (v_q),
    .frac_i       (frac),
    .gate_i       (gate_q[v_q]),
    .s0_i         (rom_data_a),
    .s1_i         (rom_data_b),
    .out_valid_o  (out_valid),
    .out_voice_o  (out_voice),
    .out_sample_o (out_sample)
  );

  assign frame_done = frame_done_q;
  assign busy       = (state_q != IDLE);
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_wavetable_voice_scheduler.sv
// Self-checking bench for wavetable_voice_scheduler: behavioural 1-cycle
// ROM, a voice-state reference model and an output scoreboard.
module tb_wavetable_voice_scheduler;

  localparam int VOICES  = 16;
  localparam int PHASE_W = 16;
  localparam int VID_W   = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               sample_tick, cfg_we, cfg_gate, ovr_clr;
  logic [VID_W-1:0]   cfg_voice;
  logic [6:0]         cfg_prog;
  logic [PHASE_W-1:0] cfg_step;
  logic               rom_re_a, rom_re_b;
  logic [5:0]         rom_addr_a_sample, rom_addr_b_sample;
  logic [6:0]         rom_addr_a_prog, rom_addr_b_prog;
  logic [7:0]         rom_data_a, rom_data_b;
  logic               out_valid, frame_done, busy, overrun;
  logic [VID_W-1:0]   out_voice;
  logic [7:0]         out_sample;

  always #5 clk = ~clk;

  wavetable_voice_scheduler #(
    .VOICES  (VOICES),
    .PHASE_W (PHASE_W)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .sample_tick       (sample_tick),
    .cfg_we            (cfg_we),
    .cfg_voice         (cfg_voice),
    .cfg_prog          (cfg_prog),
    .cfg_step          (cfg_step),
    .cfg_gate          (cfg_gate),
    .ovr_clr           (ovr_clr),
    .rom_re_a          (rom_re_a),
    .rom_re_b          (rom_re_b),
    .rom_addr_a_sample (rom_addr_a_sample),
    .rom_addr_b_sample (rom_addr_b_sample),
    .rom_addr_a_prog   (rom_addr_a_prog),
    .rom_addr_b_prog   (rom_addr_b_prog),
    .rom_data_a        (rom_data_a),
    .rom_data_b        (rom_data_b),
    .out_valid         (out_valid),
    .out_voice         (out_voice),
    .out_sample        (out_sample),
    .frame_done        (frame_done),
    .busy              (busy),
    .overrun           (overrun)
  );

  // Behavioural ROM, 1-cycle read latency.
  logic [7:0] rom [0:8191];
  always @(posedge clk) begin
    if (rom_re_a) rom_data_a <= rom[{rom_addr_a_prog, rom_addr_a_sample}];
    if (rom_re_b) rom_data_b <= rom[{rom_addr_b_prog, rom_addr_b_sample}];
  end

  // Reference voice state.
  logic [6:0]         m_prog  [VOICES];
  logic [PHASE_W-1:0] m_step  [VOICES];
  logic [PHASE_W-1:0] m_phase [VOICES];
  logic               m_gate  [VOICES];

  // Expected issue slots of the current frame and what the DUT showed.
  logic       e_re   [VOICES];
  logic [6:0] e_prog [VOICES];
  logic [5:0] e_idx  [VOICES];
  logic [5:0] seen_a [VOICES];
  logic [5:0] seen_b [VOICES];
  logic [6:0] seen_p [VOICES];
  logic [7:0] last_out [VOICES];

  typedef struct {
    logic [VID_W-1:0] voice;
    logic [7:0]       sample;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  int n_tests = 0;
  int n_fail  = 0;
  int out_cnt = 0;
  int done_cnt = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] interp(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] f);
    int s0, s1, p;
    s0 = int'($signed(a));
    s1 = int'($signed(b));
    p  = (s1 - s0) * int'(f);
    return 8'(s0 + (p >>> 8));
  endfunction

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      out_cnt++;
      if (sb_q.size() == 0) begin
        check("unexpected_output", 64'(out_voice), 64'hFFFF);
      end else begin
        mon_e = sb_q.pop_front();
        check("out_voice", 64'(out_voice), 64'(mon_e.voice));
        check("out_sample", 64'(out_sample), 64'(mon_e.sample));
        last_out[mon_e.voice] = out_sample;
      end
    end
    if (!rst && frame_done) done_cnt++;
  end

  task automatic model_reset();
    for (int v = 0; v < VOICES; v++) begin
      m_prog[v] = '0; m_step[v] = '0; m_phase[v] = '0; m_gate[v] = 1'b0;
    end
  endtask

  task automatic model_cfg(input int v, input logic [6:0] p, input logic [15:0] s, input logic g);
    if (g && !m_gate[v]) m_phase[v] = '0;
    m_prog[v] = p; m_step[v] = s; m_gate[v] = g;
  endtask

  // Push the expected outputs of one frame and advance the model phases.
  task automatic push_frame();
    for (int v = 0; v < VOICES; v++) begin
      logic [5:0] idx, idx1;
      logic [7:0] frac;
      exp_t e;
      idx  = m_phase[v][15:10];
      frac = m_phase[v][9:2];
      idx1 = idx + 6'd1;
      e_re[v]   = m_gate[v];
      e_prog[v] = m_prog[v];
      e_idx[v]  = idx;
      e.voice   = VID_W'(v);
      e.sample  = m_gate[v] ? interp(rom[{m_prog[v], idx}], rom[{m_prog[v], idx1}], frac) : 8'h00;
      sb_q.push_back(e);
      if (m_gate[v]) m_phase[v] = m_phase[v] + m_step[v];
    end
  endtask

  task automatic cfg(input int v, input logic [6:0] p, input logic [15:0] s, input logic g);
    @(negedge clk);
    cfg_we = 1'b1; cfg_voice = VID_W'(v); cfg_prog = p; cfg_step = s; cfg_gate = g;
    @(negedge clk);
    cfg_we = 1'b0;
    model_cfg(v, p, s, g);
  endtask

  // One frame; optional extra tick / ovr_clr / cfg write driven during the
  // issue slot of voice tick_at / clr_at / cfg_at.
  task automatic run_frame(input int tick_at = -1, input int clr_at = -1,
                           input int cfg_at = -1, input int cv = 0,
                           input logic [6:0] cp = 0, input logic [15:0] cs = 0,
                           input logic cg = 0);
    int done0;
    @(negedge clk);
    out_cnt = 0;
    done0   = done_cnt;
    check("idle_before_tick", 64'(busy), 64'd0);
    push_frame();
    sample_tick = 1'b1;
    for (int i = 0; i < VOICES; i++) begin
      @(negedge clk);
      sample_tick = 1'b0; ovr_clr = 1'b0; cfg_we = 1'b0;
      if (i == 0) check("busy_in_issue", 64'(busy), 64'd1);
      if (i == 1) check("latency_not_yet", 64'(out_valid), 64'd0);
      if (i == 2) check("latency_first_valid", 64'(out_valid), 64'd1);
      seen_a[i] = rom_addr_a_sample;
      seen_b[i] = rom_addr_b_sample;
      seen_p[i] = rom_addr_a_prog;
      check("rom_re_a", 64'(rom_re_a), 64'(e_re[i]));
      check("rom_re_b", 64'(rom_re_b), 64'(e_re[i]));
      if (e_re[i]) begin
        check("addr_a_prog", 64'(rom_addr_a_prog), 64'(e_prog[i]));
        check("addr_b_prog", 64'(rom_addr_b_prog), 64'(e_prog[i]));
        check("addr_a_idx", 64'(rom_addr_a_sample), 64'(e_idx[i]));
        check("addr_b_idx", 64'(rom_addr_b_sample), 64'(6'(e_idx[i] + 6'd1)));
      end
      if (i == tick_at) sample_tick = 1'b1;
      if (i == clr_at) ovr_clr = 1'b1;
      if (i == cfg_at) begin
        cfg_we = 1'b1; cfg_voice = VID_W'(cv); cfg_prog = cp; cfg_step = cs; cfg_gate = cg;
      end
    end
    @(negedge clk);
    sample_tick = 1'b0; ovr_clr = 1'b0; cfg_we = 1'b0;
    if (cfg_at >= 0) model_cfg(cv, cp, cs, cg);
    @(negedge clk);
    check("last_output_valid", 64'(out_valid), 64'd1);
    check("frame_done_early", 64'(frame_done), 64'd0);
    @(negedge clk);
    check("frame_done_pulse", 64'(frame_done), 64'd1);
    check("valid_after_frame", 64'(out_valid), 64'd0);
    check("busy_after_frame", 64'(busy), 64'd0);
    @(negedge clk);
    check("frame_done_one_cycle", 64'(frame_done), 64'd0);
    check("no_queued_frame", 64'(busy), 64'd0);
    check("frame_done_count", 64'(done_cnt - done0), 64'd1);
    check("frame_out_count", 64'(out_cnt), 64'(VOICES));
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; sample_tick = 1'b0; cfg_we = 1'b0; cfg_gate = 1'b0; ovr_clr = 1'b0;
    cfg_voice = '0; cfg_prog = '0; cfg_step = '0;
    rom_data_a = '0; rom_data_b = '0;
    for (int a = 0; a < 8192; a++) rom[a] = 8'($urandom);
    rom[9*64 + 0]  = 8'h10; rom[9*64 + 1]  = 8'h30;
    rom[10*64 + 0] = 8'h70; rom[10*64 + 1] = 8'h90;
    model_reset();

    // Reset state of every output.
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {rom_re_a, rom_re_b, rom_addr_a_sample, rom_addr_b_sample, rom_addr_a_prog,
           rom_addr_b_prog, out_valid, out_voice, out_sample, frame_done, busy, overrun},
          64'd0);
    rst = 1'b0;

    // Voice 0 steps one sample per frame; other voices stay silent.
    cfg(0, 7'd5, 16'h0400, 1'b1);
    for (int k = 0; k < 3; k++) begin
      run_frame();
      check("v0_plain_sample", 64'(last_out[0]), 64'(rom[5*64 + k]));
      check("v1_silent", 64'(last_out[1]), 64'd0);
    end

    // Reset in the middle of a frame.
    @(negedge clk);
    push_frame();
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreset_valid", 64'(out_valid), 64'd0);
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_re", 64'(rom_re_a), 64'd0);
    sb_q.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("no_output_after_reset", 64'(out_valid), 64'd0);
    end
    run_frame();
    check("post_reset_v0_silent", 64'(last_out[0]), 64'd0);

    // Interpolation at frac 0x80.
    cfg(2, 7'd9, 16'h0200, 1'b1);
    cfg(4, 7'd10, 16'h0200, 1'b1);
    run_frame();
    check("interp_frac0", 64'(last_out[2]), 64'h10);
    run_frame();
    check("interp_mid_pos", 64'(last_out[2]), 64'h20);
    check("interp_mid_cross", 64'(last_out[4]), 64'h00);

    // Phase wrap: restart voice 1, walk to 0xFC00, then single-sample steps.
    cfg(1, 7'd3, 16'h7E00, 1'b0);
    cfg(1, 7'd3, 16'h7E00, 1'b1);
    run_frame();
    run_frame();
    cfg(1, 7'd3, 16'h0400, 1'b1);
    run_frame();
    check("wrap_addr_a", 64'(seen_a[1]), 64'd63);
    check("wrap_addr_b", 64'(seen_b[1]), 64'd0);
    check("wrap_sample", 64'(last_out[1]), 64'(rom[3*64 + 63]));
    run_frame();
    check("wrapped_addr_a", 64'(seen_a[1]), 64'd0);
    check("wrapped_sample", 64'(last_out[1]), 64'(rom[3*64 + 0]));

    // Overrun handling.
    run_frame(.tick_at(5));
    check("overrun_set", 64'(overrun), 64'd1);
    @(negedge clk); ovr_clr = 1'b1;
    @(negedge clk); ovr_clr = 1'b0;
    check("overrun_cleared", 64'(overrun), 64'd0);
    run_frame(.tick_at(4), .clr_at(4));
    check("overrun_set_wins", 64'(overrun), 64'd1);
    @(negedge clk); ovr_clr = 1'b1;
    @(negedge clk); ovr_clr = 1'b0;
    check("overrun_cleared_again", 64'(overrun), 64'd0);

    // Config write landing on voice 3's own issue slot.
    run_frame(.cfg_at(3), .cv(3), .cp(7'd12), .cs(16'h0100), .cg(1'b1));
    check("cfg_collide_old_gate", 64'(last_out[3]), 64'd0);
    run_frame();
    check("cfg_collide_new_prog", 64'(seen_p[3]), 64'd12);
    check("cfg_collide_phase0", 64'(seen_a[3]), 64'd0);
    check("cfg_collide_sample", 64'(last_out[3]), 64'(rom[12*64 + 0]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
